// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding, the
// read data returned on a forced (timeout) completion, and grant encodings.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StBusyM0 = 2'b01,
        StBusyM1 = 2'b10
    } arb_state_e;

    localparam logic [31:0] TimeoutRdata = 32'hFFFF_FFFF;

    localparam logic [1:0] GrantNone = 2'b00;
    localparam logic [1:0] GrantM0   = 2'b01;
    localparam logic [1:0] GrantM1   = 2'b10;

    // Grant vector that corresponds to a given arbiter state.
    function automatic logic [1:0] grant_of(arb_state_e st);
        case (st)
            StBusyM0: return GrantM0;
            StBusyM1: return GrantM1;
            default:  return GrantNone;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_timeout.sv
// Timeout counter for the memory arbiter.
// Ports:
//   clk     - clock
//   reset   - synchronous active-high reset, clears the count
//   clear   - clears the count (held while the arbiter is idle)
//   enable  - counts one BUSY cycle without bus completion
//   expired - count has reached TIMEOUT_CYCLES
module mem_arbiter_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] count_q;

    // Holds at the limit so a stalled enable can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + TO_W'(1);
        end
    end

    assign expired = (count_q == TO_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a shared memory bus.
// Master 0 is the CPU side, master 1 the DMA side. One transaction is in
// flight at a time; each transaction is followed by at least one idle cycle.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   mX_valid/wstrb/addr/wdata - master X request (wstrb == 0 means read)
//   mX_ready/rdata      - master X completion and read data
//   s_valid/wstrb/addr/wdata  - request to the shared bus
//   s_ready/rdata       - shared bus completion and read data
//   grant               - registered one-hot owner, 00 when idle
//   err_timeout         - one-cycle pulse on forced completion
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        err_timeout
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;   // last served master: 0 = m0, 1 = m1
    logic [1:0] grant_q, grant_d;

    logic        busy;
    logic        sel1;
    logic        req_valid;
    logic [3:0]  req_wstrb;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        to_expired;

    assign busy = (state_q != StIdle);
    assign sel1 = (state_q == StBusyM1);

    // Request of whichever master owns the bus (only meaningful while busy).
    assign req_valid = sel1 ? m1_valid : m0_valid;
    assign req_wstrb = sel1 ? m1_wstrb : m0_wstrb;
    assign req_addr  = sel1 ? m1_addr  : m0_addr;
    assign req_wdata = sel1 ? m1_wdata : m0_wdata;

    mem_arbiter_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (!busy),
        .enable  (busy && !s_ready),
        .expired (to_expired)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        s_valid     = 1'b0;
        s_wstrb     = '0;
        s_addr      = '0;
        s_wdata     = '0;
        rsp_ready   = 1'b0;
        rsp_rdata   = '0;
        err_timeout = 1'b0;

        case (state_q)
            StIdle: begin
                // On a tie, m0 wins unless it was the one served last.
                if (m0_valid && (!m1_valid || last_q)) begin
                    state_d = StBusyM0;
                end else if (m1_valid) begin
                    state_d = StBusyM1;
                end
            end
            StBusyM0, StBusyM1: begin
                s_valid = req_valid;
                s_wstrb = req_wstrb;
                s_addr  = req_addr;
                s_wdata = req_wdata;
                if (!req_valid) begin
                    // Master abandoned its request: drop it silently.
                    state_d = StIdle;
                end else if (s_ready) begin
                    rsp_ready = 1'b1;
                    rsp_rdata = s_rdata;
                    state_d   = StIdle;
                    last_d    = sel1;
                end else if (to_expired) begin
                    rsp_ready   = 1'b1;
                    rsp_rdata   = TimeoutRdata;
                    err_timeout = 1'b1;
                    s_valid     = 1'b0;
                    state_d     = StIdle;
                    last_d      = sel1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        m0_ready = rsp_ready && !sel1;
        m0_rdata = sel1 ? '0 : rsp_rdata;
        m1_ready = rsp_ready && sel1;
        m1_rdata = sel1 ? rsp_rdata : '0;

        // Nothing may be signalled while reset is held, even mid-transaction.
        if (reset) begin
            s_valid     = 1'b0;
            m0_ready    = 1'b0;
            m1_ready    = 1'b0;
            err_timeout = 1'b0;
        end

        grant_d = grant_of(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            grant_q <= GrantNone;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  grant;
    logic        err_timeout;

    mem_arbiter #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;        // wait cycles before the bus answers
        logic [31:0] rd;         // data the bus returns
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cyc;    // BUSY cycle (1-based) in which ready is expected
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    vec_t       vq0[$], vq1[$];
    rsp_t       exp0[$], exp1[$];
    logic [1:0] exp_grant[$];

    int          n_vec = 0, n_err = 0;
    int          cur_lat[2];
    logic [31:0] cur_rd[2], cur_addr[2], cur_wdata[2];
    logic [3:0]  cur_wstrb[2];
    logic        idle_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int m, input logic v, input logic [3:0] ws,
                           input logic [31:0] a, input logic [31:0] wd);
        cur_wstrb[m] = ws;
        cur_addr[m]  = a;
        cur_wdata[m] = wd;
        if (m == 0) begin
            m0_valid = v; m0_wstrb = ws; m0_addr = a; m0_wdata = wd;
        end else begin
            m1_valid = v; m1_wstrb = ws; m1_addr = a; m1_wdata = wd;
        end
    endtask

    function automatic vec_t mk(input logic [3:0] ws, input logic [31:0] a,
                                input logic [31:0] wd, input int lat, input logic [31:0] rd,
                                input logic to);
        vec_t v;
        v.wstrb = ws; v.addr = a; v.wdata = wd; v.lat = lat; v.rd = rd;
        v.exp_err   = to;
        v.exp_rdata = to ? 32'hFFFF_FFFF : rd;
        v.exp_cyc   = to ? int'(TO) + 1 : lat + 1;
        return v;
    endfunction

    // Issues queued vectors for master m back to back, holding valid between them.
    task automatic run_master(input int m);
        vec_t v;
        rsp_t e;
        int   t;
        logic rdy;
        while ((m == 0 && vq0.size() > 0) || (m == 1 && vq1.size() > 0)) begin
            v = (m == 0) ? vq0.pop_front() : vq1.pop_front();
            e.rdata = v.exp_rdata; e.err = v.exp_err; e.cyc = v.exp_cyc;
            if (m == 0) exp0.push_back(e); else exp1.push_back(e);
            cur_lat[m] = v.lat;
            cur_rd[m]  = v.rd;
            set_req(m, 1'b1, v.wstrb, v.addr, v.wdata);
            t = 0;
            do begin
                @(negedge clk);
                t++;
                rdy = (m == 0) ? m0_ready : m1_ready;
            end while (!rdy && t < 40);
            if (!rdy) check($sformatf("m%0d_ready_wait", m), 32'(rdy), 32'd1);
            @(posedge clk); #1;
        end
        set_req(m, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Bus responder: answers in BUSY cycle lat+1 of the granted master's request.
    int rcnt = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (grant != 2'b00) begin
                rcnt++;
                s_ready = (rcnt == cur_lat[grant[1]] + 1);
                s_rdata = s_ready ? cur_rd[grant[1]] : 32'h0;
            end else begin
                rcnt    = 0;
                s_ready = idle_ready;
                s_rdata = idle_ready ? 32'hDEAD_BEEF : 32'h0;
            end
        end
    end

    // Monitor / scoreboard.
    logic [1:0] prev_grant = 2'b00;
    logic       prev_done = 1'b0;
    int         busy_cyc = 0;
    always @(negedge clk) begin : monitor
        rsp_t e;
        int   g;
        if (reset) begin
            prev_done = 1'b0;
            prev_grant = grant;
        end else begin
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                busy_cyc = 0;
                if (exp_grant.size() == 0) check("grant_unexpected", 32'(grant), 32'd0);
                else check("grant_order", 32'(grant), 32'(exp_grant.pop_front()));
            end
            if (grant != 2'b00) busy_cyc++;
            if (prev_done) check("idle_after_done", 32'(grant), 32'd0);
            if (s_valid) begin
                g = grant[1] ? 1 : 0;
                check("s_addr", s_addr, cur_addr[g]);
                check("s_wdata", s_wdata, cur_wdata[g]);
                check("s_wstrb", 32'(s_wstrb), 32'(cur_wstrb[g]));
            end
            if (m0_ready && m1_ready) begin
                check("both_ready", 32'd1, 32'd0);
            end else if (m0_ready || m1_ready) begin
                g = m1_ready ? 1 : 0;
                if ((g == 0 && exp0.size() == 0) || (g == 1 && exp1.size() == 0)) begin
                    check($sformatf("m%0d_ready_unexpected", g), 32'd1, 32'd0);
                end else begin
                    e = (g == 0) ? exp0.pop_front() : exp1.pop_front();
                    check($sformatf("m%0d_rdata", g), g ? m1_rdata : m0_rdata, e.rdata);
                    check($sformatf("m%0d_other_rdata", g), g ? m0_rdata : m1_rdata, 32'h0);
                    check($sformatf("m%0d_err_timeout", g), 32'(err_timeout), 32'(e.err));
                    check($sformatf("m%0d_latency", g), 32'(busy_cyc), 32'(e.cyc));
                    if (e.err) check("s_valid_on_timeout", 32'(s_valid), 32'd0);
                end
            end else if (err_timeout) begin
                check("stray_err_timeout", 32'd1, 32'd0);
            end
            prev_done  = m0_ready || m1_ready;
            prev_grant = grant;
        end
    end

    task automatic check_quiet(input string name);
        check({name, "_grant"}, 32'(grant), 32'd0);
        check({name, "_s_valid"}, 32'(s_valid), 32'd0);
        check({name, "_ready"}, 32'({m1_ready, m0_ready}), 32'd0);
        check({name, "_err"}, 32'(err_timeout), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("in_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_quiet("after_reset");
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        cur_lat[0] = 0; cur_lat[1] = 0;
        cur_rd[0] = '0; cur_rd[1] = '0;
        cur_addr[0] = '0; cur_addr[1] = '0;
        cur_wdata[0] = '0; cur_wdata[1] = '0;
        cur_wstrb[0] = '0; cur_wstrb[1] = '0;
        do_reset();

        // Single m0 read, bus answers after 2 wait cycles.
        exp_grant.push_back(2'b01);
        vq0.push_back(mk(4'h0, 32'h0000_0010, 32'h0, 2, 32'h1234_5678, 1'b0));
        run_master(0);

        // Simultaneous requests right after reset: m0 first, then m1.
        do_reset();
        exp_grant.push_back(2'b01);
        exp_grant.push_back(2'b10);
        vq0.push_back(mk(4'hF, 32'h0000_0100, 32'hA5A5_0000, 1, 32'h0000_0001, 1'b0));
        vq1.push_back(mk(4'h0, 32'h0000_0200, 32'h0, 0, 32'h0BAD_F00D, 1'b0));
        fork run_master(0); run_master(1); join

        // m1 writes continuously, m0 re-requests: strict alternation.
        for (int i = 0; i < 3; i++) begin
            exp_grant.push_back(2'b01);
            exp_grant.push_back(2'b10);
            vq0.push_back(mk(4'h0, 32'h0000_1000 + 32'(4 * i), 32'h0, 0,
                             32'h3000_0000 + 32'(i), 1'b0));
            vq1.push_back(mk(4'h3, 32'h0000_2000 + 32'(4 * i), 32'h5500_0000 + 32'(i), 1,
                             32'h1111_0000 + 32'(i), 1'b0));
        end
        fork run_master(0); run_master(1); join

        // m1 read, bus never answers: forced completion.
        exp_grant.push_back(2'b10);
        vq1.push_back(mk(4'h0, 32'h0000_3000, 32'h0, 1000, 32'h0, 1'b1));
        run_master(1);

        // Bus answers in the very cycle the counter hits the limit: normal completion.
        exp_grant.push_back(2'b01);
        vq0.push_back(mk(4'h0, 32'h0000_4000, 32'h0, int'(TO), 32'hCAFE_0037, 1'b0));
        run_master(0);

        // s_ready while idle is ignored.
        idle_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_sready_grant", 32'(grant), 32'd0);
            check("idle_sready_ready", 32'({m1_ready, m0_ready}), 32'd0);
        end
        @(posedge clk); #1;
        idle_ready = 1'b0;

        // Reset in the middle of a BUSY_M1 transaction.
        exp_grant.push_back(2'b10);
        cur_lat[1] = 1000;
        cur_rd[1]  = 32'h0;
        set_req(1, 1'b1, 4'h0, 32'h0000_5000, 32'h0);
        t = 0;
        do begin @(negedge clk); t++; end while (grant != 2'b10 && t < 10);
        check("rst_test_grant_m1", 32'(grant), 32'd2);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_s_valid", 32'(s_valid), 32'd0);
        check("mid_reset_ready", 32'({m1_ready, m0_ready}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check_quiet("post_abort");

        // Tie after reset goes to m0 again.
        @(posedge clk); #1;
        exp_grant.push_back(2'b01);
        exp_grant.push_back(2'b10);
        vq0.push_back(mk(4'h0, 32'h0000_6000, 32'h0, 0, 32'h0000_00A0, 1'b0));
        vq1.push_back(mk(4'h0, 32'h0000_7000, 32'h0, 0, 32'h0000_00B1, 1'b0));
        fork run_master(0); run_master(1); join

        repeat (5) @(negedge clk);
        check("exp0_left", 32'(exp0.size()), 32'd0);
        check("exp1_left", 32'(exp1.size()), 32'd0);
        check("grant_left", 32'(exp_grant.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
